// File: rtl/control_unit.sv
// Main control decoder: opcode[15:12] -> registered 24-bit control word.
// Pure per-cycle decode; unknown or unassigned opcodes decode as illegal.
module control_unit (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:12] opcode,
  output logic [23:0]  out
);

  typedef struct packed {
    logic       halt;
    logic       illegal;
    logic       jump;
    logic       branch;
    logic [1:0] bcond;
    logic       mem_read;
    logic       mem_write;
    logic       byte_acc;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_imm;
    logic [2:0] alu_op;
    logic [1:0] imm_sel;
    logic       r0_write;
    logic       pc_write;
    logic [4:0] rsvd;
  } ctrl_t;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ANDI = 4'h1;
  localparam logic [3:0] OP_ORI  = 4'h2;
  localparam logic [3:0] OP_BLT  = 4'h4;
  localparam logic [3:0] OP_BGT  = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_LBU  = 4'hA;
  localparam logic [3:0] OP_SB   = 4'hB;
  localparam logic [3:0] OP_LW   = 4'hC;
  localparam logic [3:0] OP_SW   = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_FN  = 3'b100;

  localparam logic [1:0] IMM_SX = 2'b01;
  localparam logic [1:0] IMM_ZX = 2'b10;

  localparam logic [1:0] BC_LT = 2'b00;
  localparam logic [1:0] BC_GT = 2'b01;
  localparam logic [1:0] BC_EQ = 2'b10;

  ctrl_t dec;

  always_comb begin
    dec = '0;
    // Non-matching values, including X/Z, fall to the illegal NOP.
    unique case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_FN;
        dec.r0_write  = 1'b1;
        dec.pc_write  = 1'b1;
      end
      OP_ANDI: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.alu_op      = ALU_AND;
        dec.imm_sel     = IMM_ZX;
        dec.pc_write    = 1'b1;
      end
      OP_ORI: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.alu_op      = ALU_OR;
        dec.imm_sel     = IMM_ZX;
        dec.pc_write    = 1'b1;
      end
      OP_BLT, OP_BGT, OP_BEQ: begin
        dec.branch   = 1'b1;
        dec.alu_op   = ALU_SUB;
        dec.imm_sel  = IMM_SX;
        dec.pc_write = 1'b1;
        if (opcode == OP_BGT)      dec.bcond = BC_GT;
        else if (opcode == OP_BEQ) dec.bcond = BC_EQ;
        else                       dec.bcond = BC_LT;
      end
      OP_JMP: begin
        dec.jump     = 1'b1;
        dec.imm_sel  = IMM_SX;
        dec.pc_write = 1'b1;
      end
      OP_LBU, OP_LW: begin
        dec.mem_read    = 1'b1;
        dec.byte_acc    = (opcode == OP_LBU);
        dec.reg_write   = 1'b1;
        dec.mem_to_reg  = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.alu_op      = ALU_ADD;
        dec.imm_sel     = IMM_SX;
        dec.pc_write    = 1'b1;
      end
      OP_SB, OP_SW: begin
        dec.mem_write   = 1'b1;
        dec.byte_acc    = (opcode == OP_SB);
        dec.alu_src_imm = 1'b1;
        dec.alu_op      = ALU_ADD;
        dec.imm_sel     = IMM_SX;
        dec.pc_write    = 1'b1;
      end
      OP_HALT: begin
        dec.halt = 1'b1;
      end
      default: begin
        dec.illegal  = 1'b1;
        dec.pc_write = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= '0;
    else     out <= dec;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: table sweep, illegal/X opcodes,
// async reset, HALT release and mid-cycle opcode glitches.
module tb_control_unit;

  logic        clk;
  logic        rst;
  logic [3:0]  op;
  logic [23:0] out;

  int total = 0;
  int bad   = 0;

  control_unit dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (op),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] tbl(input logic [3:0] o);
    if ($isunknown(o)) return 24'h400020;
    case (o)
      4'h0: return 24'h004860;
      4'h1: return 24'h005520;
      4'h2: return 24'h005720;
      4'h4: return 24'h1002A0;
      4'h5: return 24'h1402A0;
      4'h6: return 24'h1802A0;
      4'h7: return 24'h2000A0;
      4'hA: return 24'h02F0A0;
      4'hB: return 24'h0190A0;
      4'hC: return 24'h0270A0;
      4'hD: return 24'h0110A0;
      4'hF: return 24'h800000;
      default: return 24'h400020;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [23:0] exp);
    total++;
    assert (out === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, out, exp);
    end
  endtask

  task automatic step(input logic [3:0] o, input string tag);
    @(negedge clk);
    op = o;
    @(posedge clk);
    #1;
    chk(tag, tbl(op));
  endtask

  logic [3:0] sweep [14] = '{4'h0, 4'hF, 4'h1, 4'h2, 4'hA, 4'hB, 4'hC,
                             4'hD, 4'h5, 4'h4, 4'h6, 4'h7, 4'hF, 4'h0};
  logic [3:0] ills [4] = '{4'h3, 4'h8, 4'h9, 4'hE};

  initial begin
    rst = 1'b1;
    op  = 4'h0;
    #2;
    chk("reset_init", 24'h000000);
    @(posedge clk);
    #1;
    chk("reset_held_edge", 24'h000000);
    @(negedge clk);
    rst = 1'b0;

    foreach (sweep[i]) step(sweep[i], $sformatf("sweep_%0d_op%h", i, sweep[i]));
    foreach (ills[i]) step(ills[i], $sformatf("illegal_op%h", ills[i]));

    step(4'bx, "illegal_x");
    step(4'h0, "after_x_rtype");

    step(4'hF, "halt");
    step(4'h1, "halt_release_andi");

    // Async reset mid-cycle while an R-type word is held.
    step(4'h0, "pre_reset_rtype");
    #2;
    rst = 1'b1;
    #1;
    chk("reset_async", 24'h000000);
    @(negedge clk);
    op = 4'h1;
    @(posedge clk);
    #1;
    chk("reset_hold_andi", 24'h000000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_release_andi", 24'h005520);

    // Glitchy opcode within one period.
    step(4'h0, "glitch_base");
    @(negedge clk);
    op = 4'hC;
    #1;
    op = 4'hD;
    #1;
    chk("glitch_no_change", 24'h004860);
    @(posedge clk);
    #1;
    chk("glitch_edge_sw", 24'h0110A0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
